// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//
// Purpose:
//   Owns the instruction address. Runs a three-phase fetch handshake
//   (IDLE -> FETCH -> EXEC -> FETCH ...) against instruction memory.
//   It holds each fetched instruction valid until the control unit retires it
//   with pc_step. On each retire it picks the next PC from return / call /
//   branch / sequential, in that priority order. It also keeps a small LIFO of
//   return addresses for subroutine support.
//
// Ports:
//   clk          in   1       system clock, rising-edge active
//   rst_n        in   1       asynchronous active-low reset
//   no_jump      in   1       1 = sequential (pc+1), 0 = load jump_addr
//   jump_addr    in   ADDR_W  branch/call target, sampled with pc_step
//   call         in   1       retiring instruction is a call
//   ret          in   1       retiring instruction is a return
//   pc_step      in   1       retire current instruction (only honoured in EXEC)
//   imem_ack     in   1       instruction memory served the request
//   imem_req     out  1       registered fetch request
//   imem_addr    out  ADDR_W  fetch address, always equal to pc
//   instr_valid  out  1       fetched instruction awaiting pc_step
//   pc           out  ADDR_W  current program counter
//   stack_err    out  1       sticky stack overflow/underflow flag
// -----------------------------------------------------------------------------

// Runtime invariants of the program counter, kept apart from the datapath.
module program_counter_chk #(
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = 3
) (
  input logic            clk,
  input logic            rst_n,
  input logic            imem_req,
  input logic            instr_valid,
  input logic [SP_W-1:0] sp
);

  // A request and a valid instruction are never presented together.
  a_req_valid_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_req && instr_valid));

  // The stack pointer never runs past the stack depth.
  a_sp_range : assert property (@(posedge clk) disable iff (!rst_n)
    sp <= SP_W'(STACK_DEPTH));

endmodule

module program_counter #(
  parameter int                 ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = {ADDR_W{1'b0}},
  parameter int                 STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              no_jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              call,
  input  logic              ret,
  input  logic              pc_step,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_err
);

  // Index width addresses one entry; the pointer needs one more bit so that
  // it can also express "full" (== STACK_DEPTH).
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0]   SP_EMPTY = {SP_W{1'b0}};
  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stack_err_q, stack_err_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc_s;
  logic [SP_W-1:0]   sp_dec_s;
  logic [IDX_W-1:0]  push_idx_s;
  logic [IDX_W-1:0]  pop_idx_s;
  logic              step_s;

  // pc+1 wraps naturally at ADDR_W bits; the same value is the return address.
  assign pc_inc_s   = pc_q + ADDR_ONE;
  assign sp_dec_s   = sp_q - SP_ONE;
  // Push only happens when not full, so the pointer's low bits are a valid
  // index there; pop only happens when not empty, likewise for pointer-1.
  assign push_idx_s = sp_q[IDX_W-1:0];
  assign pop_idx_s  = sp_dec_s[IDX_W-1:0];
  assign step_s     = pc_step && instr_valid_q;

  // Next-state, next-PC and stack update logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    sp_d          = sp_q;
    stack_d       = stack_q;
    stack_err_d   = stack_err_q;
    imem_req_d    = 1'b0;
    instr_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
      end

      ST_FETCH: begin
        if (imem_ack && imem_req_q) begin
          state_d       = ST_EXEC;
          instr_valid_d = 1'b1;
        end else begin
          imem_req_d = 1'b1;
        end
      end

      ST_EXEC: begin
        if (step_s) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
          if (ret) begin
            // Return wins over call when both are flagged.
            if (sp_q != SP_EMPTY) begin
              sp_d = sp_dec_s;
              pc_d = stack_q[pop_idx_s];
            end else begin
              stack_err_d = 1'b1;
              pc_d        = pc_inc_s;
            end
          end else if (call) begin
            // The call target is taken even when the push has to be dropped.
            pc_d = jump_addr;
            if (sp_q == SP_FULL) begin
              stack_err_d = 1'b1;
            end else begin
              stack_d[push_idx_s] = pc_inc_s;
              sp_d                = sp_q + SP_ONE;
            end
          end else if (!no_jump) begin
            pc_d = jump_addr;
          end else begin
            pc_d = pc_inc_s;
          end
        end else begin
          instr_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC, flags and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_ADDR;
      sp_q          <= SP_EMPTY;
      stack_err_q   <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      sp_q          <= sp_d;
      stack_err_q   <= stack_err_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Return-address storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign stack_err   = stack_err_q;

  program_counter_chk #(
    .STACK_DEPTH (STACK_DEPTH),
    .SP_W        (SP_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req_q),
    .instr_valid (instr_valid_q),
    .sp          (sp_q)
  );

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//
// Self-checking bench for program_counter (ADDR_W=8, STACK_DEPTH=4).
// A behavioural model tracks the fetch phase, PC and the return stack. The
// return stack is a plain queue. A compare process checks every DUT output
// against the model on each falling edge. Directed scenarios add literal
// expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_program_counter;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              no_jump   = 1'b1;
  logic [ADDR_W-1:0] jump_addr = 8'h00;
  logic              call      = 1'b0;
  logic              ret       = 1'b0;
  logic              pc_step   = 1'b0;
  logic              imem_ack  = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              stack_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_pc    = 0;
  bit m_idle  = 1'b1;
  bit m_req   = 1'b0;
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;
  int m_stack[$];

  program_counter #(
    .ADDR_W      (ADDR_W),
    .RESET_ADDR  (8'h00),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .no_jump     (no_jump),
    .jump_addr   (jump_addr),
    .call        (call),
    .ret         (ret),
    .pc_step     (pc_step),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 0;
    m_idle  = 1'b1;
    m_req   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_stack.delete();
  endtask

  // One rising edge of the model, from the rules of the fetch/retire protocol.
  task automatic model_advance();
    if (m_idle) begin
      m_idle = 1'b0;
      m_req  = 1'b1;
    end else if (m_req) begin
      if (imem_ack) begin
        m_req   = 1'b0;
        m_valid = 1'b1;
      end
    end else if (m_valid && pc_step) begin
      m_valid = 1'b0;
      m_req   = 1'b1;
      if (ret) begin
        if (m_stack.size() > 0) begin
          m_pc = m_stack.pop_back();
        end else begin
          m_err = 1'b1;
          m_pc  = (m_pc + 1) % 256;
        end
      end else if (call) begin
        if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 256);
        else m_err = 1'b1;
        m_pc = jump_addr;
      end else if (!no_jump) begin
        m_pc = jump_addr;
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  // Advance one clock: model follows the rising edge, then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_advance();
    @(negedge clk);
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", imem_req, m_req);
    chk("instr_valid", instr_valid, m_valid);
    chk("stack_err", stack_err, m_err);
  end

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic do_step(input logic nj, input logic [7:0] ja, input logic c, input logic r);
    wait_valid();
    pc_step   = 1'b1;
    no_jump   = nj;
    jump_addr = ja;
    call      = c;
    ret       = r;
    tick();
    pc_step = 1'b0;
    call    = 1'b0;
    ret     = 1'b0;
    no_jump = 1'b1;
  endtask

  initial begin
    // Reset then steady ack.
    imem_ack = 1'b1;
    tick();
    tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("first_req", imem_req, 1'b1);
    chk("first_req_addr", imem_addr, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      do_step(1'b1, 8'h00, 1'b0, 1'b0);
      chk("seq_pc", pc, k);
    end

    // Taken branch at pc=5 with a 3-cycle fetch stall.
    wait_valid();
    imem_ack = 1'b0;
    do_step(1'b0, 8'h40, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, 8'h40);
      chk("stall_valid", instr_valid, 1'b0);
      if (i == 3) imem_ack = 1'b1;
      tick();
    end
    chk("stall_done_valid", instr_valid, 1'b1);
    chk("branch_pc", pc, 8'h40);

    // Call/return nesting.
    do_step(1'b0, 8'h10, 1'b0, 1'b0);
    chk("nest_pc0", pc, 8'h10);
    do_step(1'b1, 8'h80, 1'b1, 1'b0);
    chk("nest_pc1", pc, 8'h80);
    do_step(1'b1, 8'hA0, 1'b1, 1'b0);
    chk("nest_pc2", pc, 8'hA0);
    do_step(1'b1, 8'h00, 1'b0, 1'b1);
    chk("nest_pc3", pc, 8'h81);
    do_step(1'b1, 8'h00, 1'b0, 1'b1);
    chk("nest_pc4", pc, 8'h11);
    chk("nest_err", stack_err, 1'b0);

    // Overflow on the 5th call, underflow on the 5th return.
    do_step(1'b0, 8'h20, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] tgt;
      tgt = 8'h30 + 8'(16 * k);
      // call ignores no_jump, so alternate it
      do_step(1'(k % 2), tgt, 1'b1, 1'b0);
      chk("ovf_pc", pc, tgt);
      chk("ovf_err", stack_err, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      do_step(1'b1, 8'h00, 1'b0, 1'b1);
      chk("pop_pc", pc, 8'h51 - 8'(16 * k));
    end
    do_step(1'b1, 8'h00, 1'b0, 1'b1);
    chk("unf_pc", pc, 8'h22);
    chk("unf_err", stack_err, 1'b1);

    // Reset mid-fetch takes effect without a clock edge.
    imem_ack = 1'b0;
    chk("midfetch_req", imem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pc", pc, 8'h00);
    chk("async_req", imem_req, 1'b0);
    chk("async_valid", instr_valid, 1'b0);
    chk("async_err", stack_err, 1'b0);
    imem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_valid", instr_valid, 1'b0);

    // Wrap and call/ret priority.
    do_step(1'b0, 8'hFF, 1'b0, 1'b0);
    chk("wrap_pre", pc, 8'hFF);
    do_step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("wrap_pc", pc, 8'h00);
    do_step(1'b1, 8'h90, 1'b1, 1'b0);
    chk("prio_call", pc, 8'h90);
    do_step(1'b0, 8'h55, 1'b1, 1'b1);
    chk("prio_pop", pc, 8'h01);
    chk("prio_err", stack_err, 1'b0);
    do_step(1'b0, 8'h66, 1'b0, 1'b1);
    chk("prio_nopush", pc, 8'h02);
    chk("prio_nopush_err", stack_err, 1'b1);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      imem_ack  = ($urandom_range(0, 9) < 7);
      pc_step   = ($urandom_range(0, 1) == 1);
      call      = ($urandom_range(0, 9) == 0);
      ret       = ($urandom_range(0, 7) == 0);
      no_jump   = ($urandom_range(0, 2) != 0);
      jump_addr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
